// File: rtl/grid_chk_pkg.sv
// Shared types for grid_result_checker: FSM states, error-log entry and log depth.
package grid_chk_pkg;

    localparam int LOG_DEPTH  = 8;
    localparam int LOG_AW_MAX = 16;
    localparam int LOG_DW_MAX = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SCAN,
        FLUSH,
        REPORT
    } state_t;

    // Sized for the widest supported geometry; the checker uses the low AW/DW bits.
    typedef struct packed {
        logic [LOG_AW_MAX-1:0] addr;
        logic [LOG_DW_MAX-1:0] got;
        logic [LOG_DW_MAX-1:0] exp;
    } log_entry_t;

endpackage

// File: rtl/grid_err_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags and a synchronous clear.
// Push into a full FIFO succeeds only when a pop happens in the same cycle.
module grid_err_fifo
    import grid_chk_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = LOG_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/grid_result_checker.sv
// Waits for the solver (with watchdog), scans result RAM against golden ROM, reports results.
// Defining GRID_ERR_LOG_EN adds an 8-entry mismatch log FIFO with overflow flag.
module grid_result_checker
    import grid_chk_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = 81,
    parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int MAX_CYCLE = 10000,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dut_done,
    output logic          res_ceb,
    output logic          res_web,
    output logic [AW-1:0] res_a,
    input  logic [DW-1:0] res_q,
    output logic          gold_rd,
    output logic [AW-1:0] gold_a,
    input  logic [DW-1:0] gold_q,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_got,
    output logic [DW-1:0] first_err_exp,
    output logic [CW-1:0] cycle_cnt
`ifdef GRID_ERR_LOG_EN
    ,
    input  logic               log_pop,
    output logic               log_valid,
    output logic [AW+2*DW-1:0] log_data,
    output logic               log_ovf
`endif
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CYC_LIMIT = CW'(MAX_CYCLE - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t        state, state_nxt;
    logic [AW-1:0] addr, cmp_addr;
    logic          cmp_vld, dut_done_q;
    logic          accept, trig_rise, at_limit, mismatch;

    assign accept    = (state == IDLE) && start;
    assign trig_rise = dut_done && !dut_done_q;
    assign at_limit  = (cycle_cnt == CYC_LIMIT);
    assign mismatch  = cmp_vld && (res_q != gold_q);

    assign busy    = (state != IDLE);
    assign done    = (state == REPORT);
    assign res_ceb = (state != SCAN);
    assign res_web = 1'b1;
    assign gold_rd = (state == SCAN);
    assign res_a   = addr;
    assign gold_a  = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (trig_rise || at_limit) state_nxt = SCAN;
            SCAN:    if (addr == LAST_ADDR) state_nxt = FLUSH;
            FLUSH:   state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dut_done_q     <= 1'b0;
            cmp_vld        <= 1'b0;
            cmp_addr       <= '0;
            addr           <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            cycle_cnt      <= '0;
            first_err_addr <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
        end else begin
            dut_done_q <= dut_done;
            cmp_vld    <= (state == SCAN);
            cmp_addr   <= addr;
            case (state)
                IDLE: if (start) begin
                    pass           <= 1'b0;
                    timeout        <= 1'b0;
                    err_cnt        <= '0;
                    cycle_cnt      <= '0;
                    first_err_addr <= '0;
                    first_err_got  <= '0;
                    first_err_exp  <= '0;
                end
                WAIT: begin
                    if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
                    // A done edge in the limit cycle wins over the watchdog.
                    if (!trig_rise && at_limit) timeout <= 1'b1;
                end
                SCAN:  addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                // The last compare lands in this cycle, so fold it in directly.
                FLUSH: pass <= (err_cnt == '0) && !mismatch && !timeout;
                default: ;
            endcase
            if (mismatch) begin
                if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) begin
                    first_err_addr <= cmp_addr;
                    first_err_got  <= res_q;
                    first_err_exp  <= gold_q;
                end
            end
        end
    end

`ifdef GRID_ERR_LOG_EN
    log_entry_t log_in, log_head;
    logic       log_full, log_empty, log_drop;

    always_comb begin
        log_in      = '0;
        log_in.addr = LOG_AW_MAX'(cmp_addr);
        log_in.got  = LOG_DW_MAX'(res_q);
        log_in.exp  = LOG_DW_MAX'(gold_q);
    end

    assign log_drop  = mismatch && log_full && !(log_pop && !log_empty);
    assign log_valid = !log_empty;
    assign log_data  = {log_head.addr[AW-1:0], log_head.got[DW-1:0], log_head.exp[DW-1:0]};

    grid_err_fifo #(
        .W     ($bits(log_entry_t)),
        .DEPTH (LOG_DEPTH)
    ) u_err_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .push  (mismatch),
        .din   (log_in),
        .pop   (log_pop),
        .dout  (log_head),
        .full  (log_full),
        .empty (log_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          log_ovf <= 1'b0;
        else if (accept)   log_ovf <= 1'b0;
        else if (log_drop) log_ovf <= 1'b1;
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_grid_result_checker.sv
// Scoreboard bench for grid_result_checker: behavioural RAM/ROM, expected results queued per run.
module tb_grid_result_checker;
    localparam int DW    = 8;
    localparam int DEPTH = 81;
    localparam int AW    = 7;
    localparam int MAXC  = 1000;
    localparam int CW    = 16;

    typedef struct {
        bit pass;
        bit to;
        int err;
        int faddr;
        int fgot;
        int fexp;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          dut_done = 1'b0;
    logic          res_ceb, res_web, gold_rd, busy, done, pass, timeout;
    logic [AW-1:0] res_a, gold_a, first_err_addr;
    logic [DW-1:0] res_q, gold_q, first_err_got, first_err_exp;
    logic [CW-1:0] err_cnt, cycle_cnt;

    logic [DW-1:0] res_mem  [DEPTH];
    logic [DW-1:0] gold_mem [DEPTH];
    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            done_cnt = 0;

    grid_result_checker #(
        .DW(DW), .DEPTH(DEPTH), .MAX_CYCLE(MAXC), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dut_done(dut_done),
        .res_ceb(res_ceb), .res_web(res_web), .res_a(res_a), .res_q(res_q),
        .gold_rd(gold_rd), .gold_a(gold_a), .gold_q(gold_q),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!res_ceb) res_q  <= res_mem[res_a];
        if (gold_rd)  gold_q <= gold_mem[gold_a];
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input bit use_done, input int d);
        exp_t e;
        e.err = 0; e.faddr = 0; e.fgot = 0; e.fexp = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (res_mem[k] != gold_mem[k]) begin
                if (e.err == 0) begin
                    e.faddr = k; e.fgot = res_mem[k]; e.fexp = gold_mem[k];
                end
                e.err++;
            end
        end
        e.to   = !use_done;
        e.cyc  = use_done ? d : MAXC;
        e.pass = (e.err == 0) && !e.to;
        return e;
    endfunction

    // d = WAIT cycles up to and including the cycle dut_done rises.
    task automatic run(input bit use_done, input int d, input bit restart);
        exp_t e;
        int   lat;
        bit   seen;
        exp_q.push_back(model(use_done, d));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (use_done) begin
            if (restart) begin
                repeat (5) @(negedge clk);
                start = 1'b1;
                @(negedge clk) start = 1'b0;
                repeat (d - 7) @(negedge clk);
            end else begin
                repeat (d - 1) @(negedge clk);
            end
            dut_done = 1'b1;
        end
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < MAXC + DEPTH + 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        dut_done = 1'b0;
        chk("done_seen", seen, 1);
        if (use_done) chk("done_latency", lat, DEPTH + 2);
        else          chk("timeout_latency", lat, MAXC + DEPTH + 1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pass", pass, e.pass);
            chk("timeout", timeout, e.to);
            chk("err_cnt", err_cnt, e.err);
            chk("cycle_cnt", cycle_cnt, e.cyc);
            chk("ceb_idle_at_done", res_ceb, 1);
            if (e.err > 0) begin
                chk("first_err_addr", first_err_addr, e.faddr);
                chk("first_err_got", first_err_got, e.fgot);
                chk("first_err_exp", first_err_exp, e.fexp);
            end
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
            chk("pass_held", pass, e.pass);
        end
    endtask

    initial begin
        int  saved;
        bit  hit;
        for (int k = 0; k < DEPTH; k++) begin
            gold_mem[k] = DW'($urandom_range(1, 9));
            res_mem[k]  = gold_mem[k];
        end

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_first_addr", first_err_addr, 0);
        chk("rst_res_ceb", res_ceb, 1);
        chk("rst_res_web", res_web, 1);
        chk("rst_gold_rd", gold_rd, 0);
        chk("rst_res_a", res_a, 0);
        chk("rst_gold_a", gold_a, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        // Matching grid.
        run(1'b1, 500, 1'b0);

        // Two mismatches, including the last address.
        res_mem[5]  = 8'h03; gold_mem[5]  = 8'h07;
        res_mem[80] = 8'h01; gold_mem[80] = 8'h09;
        run(1'b1, 50, 1'b0);
        res_mem[5] = gold_mem[5];
        res_mem[80] = gold_mem[80];

        // Watchdog expiry on a matching grid still fails.
        saved = done_cnt;
        run(1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("timeout_one_done", done_cnt, saved + 1);

        // Reset in the middle of the scan.
        res_mem[10] = gold_mem[10] + 8'd1;
        saved = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        dut_done = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!res_ceb && res_a == 7'd40) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_addr40", hit, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_res_ceb", res_ceb, 1);
        chk("abort_gold_rd", gold_rd, 0);
        chk("abort_res_a", res_a, 0);
        chk("abort_err_cnt", err_cnt, 0);
        chk("abort_cycle_cnt", cycle_cnt, 0);
        dut_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt, saved);
        rst = 1'b1;
        res_mem[10] = gold_mem[10];
        repeat (2) @(negedge clk);
        run(1'b1, 30, 1'b0);

        // dut_done in IDLE and start during WAIT are both ignored.
        saved = done_cnt;
        @(negedge clk) dut_done = 1'b1;
        @(negedge clk) dut_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done_ignored_busy", busy, 0);
        chk("idle_done_ignored_cnt", done_cnt, saved);
        res_mem[0]  = gold_mem[0] + 8'd1;
        res_mem[79] = gold_mem[79] + 8'd2;
        run(1'b1, 40, 1'b1);
        repeat (60) @(negedge clk);
        chk("one_done_per_start", done_cnt, saved + 1);
        chk("idle_after_restart", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
